// File: rtl/hack_rom_loader.sv
// hack_rom_loader
// Loads a Hack program into the instruction ROM from a framed serial byte
// stream. Each frame is LEN_HI, LEN_LO, then N words sent as HI then LO,
// then one checksum byte. The CPU is held in reset until a whole frame has
// arrived and the 8-bit sum of all its bytes is zero.
module hack_rom_loader #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              load_req,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        WAIT_LEN_HI,
        WAIT_LEN_LO,
        WAIT_HI,
        WAIT_LO,
        WAIT_CK,
        RUN,
        ERR
    } state_t;

    // Largest word count that still fits in the ROM.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    // Idle-cycle value at which the next quiet cycle aborts the frame.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [15:0]       count;     // word count N of the current frame
    logic [ADDR_W-1:0] word_idx;  // address of the next word to write
    logic [7:0]        hi_byte;   // high byte of the word being assembled
    logic [7:0]        sum;       // running 8-bit sum of accepted bytes
    logic [TO_W-1:0]   timer;     // idle cycles since the last accepted byte

    logic [7:0]  sum_next;
    logic [15:0] len_word;
    logic        len_zero;
    logic        len_over;
    logic        last_word;
    logic        timed_out;

    // Status flags that accompany a state: {cpu_reset, busy, done, error}.
    // They are registered together with the state so they change on the
    // same edge as the transition itself.
    function automatic logic [3:0] flags_of(input state_t s);
        logic in_frame;
        in_frame = (s == WAIT_LEN_LO) || (s == WAIT_HI) ||
                   (s == WAIT_LO)     || (s == WAIT_CK);
        return {s != RUN, in_frame, s == RUN, s == ERR};
    endfunction

    // Sum including the byte on rx_data, and the word count formed from it.
    assign sum_next  = sum + rx_data;
    assign len_word  = {count[15:8], rx_data};
    assign len_zero  = (len_word == 16'd0);
    assign len_over  = ({16'd0, len_word} > MAX_WORDS);
    // The LO byte being accepted completes word N-1.
    assign last_word = ((32'(word_idx) + 32'd1) == {16'd0, count});
    assign timed_out = (timer == TO_LAST);

    // Frame FSM with its datapath and registered outputs.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the values sampled at the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_LEN_HI;
            count     <= 16'd0;
            word_idx  <= '0;
            hi_byte   <= 8'd0;
            sum       <= 8'd0;
            timer     <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= 16'd0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-issued below.
            rom_we <= 1'b0;

            if (load_req) begin
                // Abandon everything; a byte arriving in this cycle is dropped.
                state    <= WAIT_LEN_HI;
                {cpu_reset, busy, done, error} <= flags_of(WAIT_LEN_HI);
                count    <= 16'd0;
                word_idx <= '0;
                sum      <= 8'd0;
                timer    <= '0;
            end else if (rx_valid) begin
                timer <= '0;
                case (state)
                    WAIT_LEN_HI: begin
                        count <= {rx_data, 8'd0};
                        sum   <= rx_data;
                        state <= WAIT_LEN_LO;
                        {cpu_reset, busy, done, error} <= flags_of(WAIT_LEN_LO);
                    end

                    WAIT_LEN_LO: begin
                        count[7:0] <= rx_data;
                        sum        <= sum_next;
                        if (len_zero) begin
                            state <= WAIT_CK;
                            {cpu_reset, busy, done, error} <= flags_of(WAIT_CK);
                        end else if (len_over) begin
                            state <= ERR;
                            {cpu_reset, busy, done, error} <= flags_of(ERR);
                        end else begin
                            state <= WAIT_HI;
                            {cpu_reset, busy, done, error} <= flags_of(WAIT_HI);
                        end
                    end

                    WAIT_HI: begin
                        hi_byte <= rx_data;
                        sum     <= sum_next;
                        state   <= WAIT_LO;
                        {cpu_reset, busy, done, error} <= flags_of(WAIT_LO);
                    end

                    WAIT_LO: begin
                        rom_we    <= 1'b1;
                        rom_addr  <= word_idx;
                        rom_wdata <= {hi_byte, rx_data};
                        word_idx  <= word_idx + 1'b1;
                        sum       <= sum_next;
                        if (last_word) begin
                            state <= WAIT_CK;
                            {cpu_reset, busy, done, error} <= flags_of(WAIT_CK);
                        end else begin
                            state <= WAIT_HI;
                            {cpu_reset, busy, done, error} <= flags_of(WAIT_HI);
                        end
                    end

                    WAIT_CK: begin
                        sum <= sum_next;
                        if (sum_next == 8'd0) begin
                            state <= RUN;
                            {cpu_reset, busy, done, error} <= flags_of(RUN);
                        end else begin
                            state <= ERR;
                            {cpu_reset, busy, done, error} <= flags_of(ERR);
                        end
                    end

                    default: begin
                        // RUN and ERR ignore bytes until load_req or reset.
                    end
                endcase
            end else if (busy) begin
                // Quiet cycle inside a frame: abort once the gap is too long.
                if (timed_out) begin
                    state <= ERR;
                    {cpu_reset, busy, done, error} <= flags_of(ERR);
                    timer <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader
// Directed frames into hack_rom_loader. Expected ROM writes are queued when
// the stimulus is issued and popped by an independent write monitor; status
// flags are checked directly at chosen points after the driving edge.
module tb_hack_rom_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 100;
    localparam int TO_W    = 20;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              load_req;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_q[$];

    hack_rom_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .load_req (load_req),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every ROM write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", rom_addr, rom_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(rom_addr), 32'(e.addr));
                check("write_data", 32'(rom_wdata), 32'(e.data));
            end
        end
    end

    // Each task leaves time at 1 ns past a rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // {cpu_reset, busy, done, error}
    task automatic check_flags(input string name, input logic [3:0] exp);
        check(name, {28'd0, cpu_reset, busy, done, error}, {28'd0, exp});
    endtask

    task automatic check_reset_values(input string name);
        check_flags(name, 4'b1000);
        check({name, "_we"}, {31'd0, rom_we}, 32'd0);
        check({name, "_addr"}, 32'(rom_addr), 32'd0);
        check({name, "_wdata"}, 32'(rom_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        load_req = 1'b0;
        idle(3);
        check_reset_values("reset_state");
        reset = 1'b0;
        idle(2);

        // Good frame, with long but legal gaps to show the idle counter clears.
        push_wr(4'd0, 16'h0003);
        push_wr(4'd1, 16'hEC10);
        send(8'h00);
        check_flags("good_after_len_hi", 4'b1100);
        send(8'h02);
        idle(90);
        send(8'h00);
        idle(90);
        send(8'h03);
        send(8'hEC);
        send(8'h10);
        check_flags("good_before_ck", 4'b1100);
        send(8'hFF);
        check_flags("good_run", 4'b0010);

        // Bytes in RUN are ignored (the monitor catches any write).
        send(8'h00);
        send(8'h01);
        send(8'h55);
        check_flags("run_ignores_bytes", 4'b0010);

        // Reload from RUN.
        pulse_load();
        check_flags("reload_from_run", 4'b1000);

        // Bad checksum: both words still written, then ERR.
        push_wr(4'd0, 16'h0003);
        push_wr(4'd1, 16'hEC10);
        send(8'h00);
        send(8'h02);
        send(8'h00);
        send(8'h03);
        send(8'hEC);
        send(8'h10);
        send(8'h00);
        check_flags("bad_ck_err", 4'b1001);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        check_flags("err_ignores_bytes", 4'b1001);

        // Empty program.
        pulse_load();
        check_flags("load_clears_error", 4'b1000);
        send(8'h00);
        send(8'h00);
        check_flags("empty_wait_ck", 4'b1100);
        send(8'h00);
        check_flags("empty_run", 4'b0010);

        // Largest legal count (16 words) is accepted.
        pulse_load();
        send(8'h00);
        send(8'h10);
        check_flags("len_max_accepted", 4'b1100);

        // One word too many is rejected right away.
        pulse_load();
        send(8'h00);
        send(8'h11);
        check_flags("oversize_err", 4'b1001);

        // Timeout: ERR exactly TIMEOUT cycles after the last byte.
        pulse_load();
        send(8'h00);
        send(8'h02);
        send(8'h00);
        idle(TIMEOUT - 1);
        check_flags("timeout_not_yet", 4'b1100);
        idle(1);
        check_flags("timeout_err", 4'b1001);

        // load_req colliding with a byte: the byte is dropped.
        pulse_load();
        send(8'h00);
        check_flags("collide_in_frame", 4'b1100);
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        load_req = 1'b0;
        check_flags("collide_dropped", 4'b1000);
        push_wr(4'd0, 16'hABCD);
        send(8'h00);
        send(8'h01);
        send(8'hAB);
        send(8'hCD);
        send(8'h87);
        check_flags("after_collide_run", 4'b0010);

        // Reset in the middle of the second word.
        pulse_load();
        push_wr(4'd0, 16'h1234);
        send(8'h00);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        reset = 1'b1;
        idle(1);
        check_reset_values("midword_reset");
        reset = 1'b0;
        idle(3);
        check_flags("after_reset_idle", 4'b1000);

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
